snake_game_ctrl: RTL and testbench

SNAKE_GAME_CTRL -- requirements
Module: snake_game_ctrl

---
 rtl/snake_pkg.sv | 57 +++++
 rtl/snake_step_timer.sv | 27 ++
 rtl/snake_game_ctrl.sv | 132 +++++++++++++
 tb/tb_snake_game_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared constants for the snake game controller: FSM state codes, direction
// encoding, PS/2 make codes, grid/timer defaults and a key decoder.
package snake_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_DEAD  = 2'd3;

    typedef logic [1:0] dir_t;
    localparam dir_t DIR_UP    = 2'd0;
    localparam dir_t DIR_DOWN  = 2'd1;
    localparam dir_t DIR_LEFT  = 2'd2;
    localparam dir_t DIR_RIGHT = 2'd3;

    localparam logic [7:0] KEY_UP    = 8'h75;
    localparam logic [7:0] KEY_DOWN  = 8'h72;
    localparam logic [7:0] KEY_LEFT  = 8'h6B;
    localparam logic [7:0] KEY_RIGHT = 8'h74;
    localparam logic [7:0] KEY_SPACE = 8'h29;
    localparam logic [7:0] KEY_ESC   = 8'h76;

    localparam int unsigned GRID_W_DEF          = 64;
    localparam int unsigned GRID_H_DEF          = 48;
    localparam int unsigned FRAMES_PER_STEP_DEF = 6;
    localparam int unsigned CNT_W               = 6;

    typedef struct packed {
        logic arrow;
        dir_t dir;
        logic space;
        logic esc;
    } key_t;

    function automatic key_t decode_key(input logic valid, input logic [7:0] code);
        key_t k;
        k = '0;
        if (valid) begin
            case (code)
                KEY_UP:    begin k.arrow = 1'b1; k.dir = DIR_UP;    end
                KEY_DOWN:  begin k.arrow = 1'b1; k.dir = DIR_DOWN;  end
                KEY_LEFT:  begin k.arrow = 1'b1; k.dir = DIR_LEFT;  end
                KEY_RIGHT: begin k.arrow = 1'b1; k.dir = DIR_RIGHT; end
                KEY_SPACE: k.space = 1'b1;
                KEY_ESC:   k.esc = 1'b1;
                default:   ;
            endcase
        end
        return k;
    endfunction

    // Opposite directions differ only in bit 0 (up/down, left/right).
    function automatic logic is_reverse(input dir_t a, input dir_t b);
        return (a[1] == b[1]) && (a[0] != b[0]);
    endfunction

endpackage

// File: rtl/snake_step_timer.sv
// Frame counter pacing snake moves: clears, holds when not advanced, and
// flags the terminal count FRAMES_PER_STEP-1.
module snake_step_timer
    import snake_pkg::*;
#(
    parameter int unsigned FRAMES_PER_STEP = FRAMES_PER_STEP_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic advance,
    output logic terminal
);

    logic [CNT_W-1:0] count;

    assign terminal = (count == CNT_W'(FRAMES_PER_STEP - 1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (advance) begin
            count <= terminal ? '0 : count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/snake_game_ctrl.sv
// Snake game control FSM: key handling, move timing, collision and score.
// Optional macro SNAKE_WRAP_EN makes the grid edges wrap instead of killing.
module snake_game_ctrl
    import snake_pkg::*;
#(
    parameter int unsigned FRAMES_PER_STEP = FRAMES_PER_STEP_DEF,
    parameter int unsigned GRID_W          = GRID_W_DEF,
    parameter int unsigned GRID_H          = GRID_H_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [7:0] key_code,
    input  logic       frame_tick,
    input  logic [6:0] head_x,
    input  logic [5:0] head_y,
    input  logic       self_hit,
    input  logic       food_eaten,
    output logic [6:0] next_x,
    output logic [5:0] next_y,
    output logic       step,
    output logic [1:0] dir,
    output logic       init_snake,
    output logic       screen_black,
    output logic       screen_pause,
    output logic       died,
    output logic [7:0] score
);

    logic [1:0] state;
    dir_t       dir_pend;
    key_t       key;
    logic       advance;
    logic       terminal;
    logic       evaluate;
    logic       wall;

    assign key = decode_key(key_valid, key_code);

    // Space/esc pre-empt the tick so a terminal count is not consumed by a
    // move that never happens.
    assign advance  = frame_tick && (state == ST_RUN) && !key.space && !key.esc;
    assign evaluate = advance && terminal;

    snake_step_timer #(
        .FRAMES_PER_STEP(FRAMES_PER_STEP)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   ((state == ST_IDLE) || (state == ST_DEAD)),
        .advance (advance),
        .terminal(terminal)
    );

    always_comb begin
        next_x = head_x;
        next_y = head_y;
        case (dir_pend)
            DIR_UP:   next_y = head_y - 6'd1;
            DIR_DOWN: next_y = head_y + 6'd1;
            DIR_LEFT: next_x = head_x - 7'd1;
            default:  next_x = head_x + 7'd1;
        endcase
`ifdef SNAKE_WRAP_EN
        case (dir_pend)
            DIR_UP:   if (head_y == 6'd0) next_y = 6'(GRID_H - 1);
            DIR_DOWN: if (32'(head_y) >= GRID_H - 1) next_y = '0;
            DIR_LEFT: if (head_x == 7'd0) next_x = 7'(GRID_W - 1);
            default:  if (32'(head_x) >= GRID_W - 1) next_x = '0;
        endcase
        wall = 1'b0;
`else
        wall = (32'(next_x) >= GRID_W) || (32'(next_y) >= GRID_H);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            dir      <= DIR_RIGHT;
            dir_pend <= DIR_RIGHT;
            score    <= '0;
            step     <= 1'b0;
            died     <= 1'b0;
        end else begin
            step <= 1'b0;
            died <= 1'b0;
            if (key.esc) begin
                state    <= ST_IDLE;
                dir      <= DIR_RIGHT;
                dir_pend <= DIR_RIGHT;
            end else if (key.space) begin
                case (state)
                    ST_IDLE: begin
                        state <= ST_RUN;
                        score <= '0;
                    end
                    ST_RUN:   state <= ST_PAUSE;
                    ST_PAUSE: state <= ST_RUN;
                    default: begin
                        state    <= ST_IDLE;
                        dir      <= DIR_RIGHT;
                        dir_pend <= DIR_RIGHT;
                    end
                endcase
            end else begin
                if (evaluate) begin
                    if (wall || self_hit) begin
                        died  <= 1'b1;
                        state <= ST_DEAD;
                    end else begin
                        step <= 1'b1;
                        dir  <= dir_pend;
                    end
                end
                // The move above used the old dir_pend; a coinciding arrow
                // only affects the following move.
                if (key.arrow && (state != ST_DEAD) && !is_reverse(key.dir, dir)) begin
                    dir_pend <= key.dir;
                end
            end
            if ((state == ST_RUN) && food_eaten && (score != 8'hFF)) begin
                score <= score + 8'd1;
            end
        end
    end

    assign init_snake   = (state == ST_IDLE);
    assign screen_black = (state == ST_IDLE);
    assign screen_pause = (state == ST_PAUSE) || (state == ST_DEAD);

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Self-checking bench for snake_game_ctrl (default and SNAKE_WRAP_EN builds).
module tb_snake_game_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_valid = 1'b0;
    logic [7:0] key_code = '0;
    logic       frame_tick = 1'b0;
    logic [6:0] head_x = 7'd10;
    logic [5:0] head_y = 6'd10;
    logic       self_hit = 1'b0;
    logic       food_eaten = 1'b0;
    logic [6:0] next_x;
    logic [5:0] next_y;
    logic       step;
    logic [1:0] dir;
    logic       init_snake;
    logic       screen_black;
    logic       screen_pause;
    logic       died;
    logic [7:0] score;

    snake_game_ctrl #(
        .FRAMES_PER_STEP(6),
        .GRID_W(64),
        .GRID_H(48)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .frame_tick  (frame_tick),
        .head_x      (head_x),
        .head_y      (head_y),
        .self_hit    (self_hit),
        .food_eaten  (food_eaten),
        .next_x      (next_x),
        .next_y      (next_y),
        .step        (step),
        .dir         (dir),
        .init_snake  (init_snake),
        .screen_black(screen_black),
        .screen_pause(screen_pause),
        .died        (died),
        .score       (score)
    );

    always #5 clk = ~clk;

    localparam logic [7:0] K_UP = 8'h75, K_DOWN = 8'h72, K_LEFT = 8'h6B;
    localparam logic [7:0] K_RIGHT = 8'h74, K_SPACE = 8'h29, K_ESC = 8'h76;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         is_died;
        logic [1:0] dir;
        int         cyc;
    } ev_t;
    ev_t exp_q[$];
    ev_t mon_e;

    typedef struct {
        logic [7:0] code;
        logic [6:0] hx;
        logic [5:0] hy;
        logic [6:0] ex;
        logic [5:0] ey;
    } vec_t;
    localparam int unsigned NV = 8;
    vec_t vecs[NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Every step/died pulse must match the oldest expected event.
    always @(negedge clk) begin
        if (step || died) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse actual step=%0d died=%0d required none (cycle %0d)",
                         step, died, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("pulse_kind", {30'd0, step, died}, mon_e.is_died ? 32'd1 : 32'd2);
                chk("pulse_cycle", cyc, mon_e.cyc);
                chk("pulse_dir", dir, mon_e.dir);
            end
        end
    end

    task automatic key(input logic [7:0] c);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = c;
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = '0;
    endtask

    task automatic do_tick(input bit ev, input bit ev_died, input logic [1:0] ev_dir,
                           input bit sh, input bit kv, input logic [7:0] kc);
        ev_t e;
        @(negedge clk);
        frame_tick = 1'b1;
        self_hit   = sh;
        key_valid  = kv;
        key_code   = kc;
        if (ev) begin
            e.is_died = ev_died;
            e.dir     = ev_dir;
            e.cyc     = cyc + 1;
            exp_q.push_back(e);
        end
        @(negedge clk);
        frame_tick = 1'b0;
        self_hit   = 1'b0;
        key_valid  = 1'b0;
        key_code   = '0;
    endtask

    task automatic ticks(input int unsigned n);
        repeat (n) do_tick(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic food(input int unsigned n);
        repeat (n) begin
            @(negedge clk);
            food_eaten = 1'b1;
            @(negedge clk);
            food_eaten = 1'b0;
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_step"}, step, 0);
        chk({tag, "_died"}, died, 0);
        chk({tag, "_init"}, init_snake, 1);
        chk({tag, "_black"}, screen_black, 1);
        chk({tag, "_pause"}, screen_pause, 0);
        chk({tag, "_dir"}, dir, 3);
        chk({tag, "_score"}, score, 0);
    endtask

    initial begin
        vecs[0] = '{K_UP,    7'd10, 6'd10, 7'd10, 6'd9};
        vecs[1] = '{K_DOWN,  7'd10, 6'd10, 7'd10, 6'd11};
        vecs[2] = '{K_LEFT,  7'd10, 6'd10, 7'd11, 6'd10};
        vecs[3] = '{8'h1C,   7'd10, 6'd10, 7'd11, 6'd10};
        vecs[4] = '{K_RIGHT, 7'd5,  6'd5,  7'd6,  6'd5};
`ifdef SNAKE_WRAP_EN
        vecs[5] = '{K_UP,    7'd20, 6'd0,  7'd20, 6'd47};
        vecs[6] = '{K_DOWN,  7'd20, 6'd47, 7'd20, 6'd0};
        vecs[7] = '{K_RIGHT, 7'd63, 6'd7,  7'd0,  6'd7};
`else
        vecs[5] = '{K_UP,    7'd20, 6'd0,  7'd20, 6'd63};
        vecs[6] = '{K_DOWN,  7'd20, 6'd47, 7'd20, 6'd48};
        vecs[7] = '{K_RIGHT, 7'd63, 6'd7,  7'd64, 6'd7};
`endif

        // Reset values while rst is held
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        chk("reset_next_x", next_x, 11);
        rst = 1'b0;

        // Direction latch and next-cell table, from IDLE each time
        for (int unsigned i = 0; i < NV; i++) begin
            key(K_ESC);
            key(vecs[i].code);
            head_x = vecs[i].hx;
            head_y = vecs[i].hy;
            #1;
            chk($sformatf("tbl%0d_next_x", i), next_x, vecs[i].ex);
            chk($sformatf("tbl%0d_next_y", i), next_y, vecs[i].ey);
            chk($sformatf("tbl%0d_idle", i), init_snake, 1);
        end

        // Start: six ticks give exactly one step, one cycle after the sixth
        key(K_ESC);
        head_x = 7'd10;
        head_y = 6'd10;
        key(K_SPACE);
        chk("run_init", init_snake, 0);
        chk("run_black", screen_black, 0);
        chk("run_pause", screen_pause, 0);
        chk("run_score", score, 0);
        ticks(5);
        do_tick(1'b1, 1'b0, 2'd3, 1'b0, 1'b0, 8'h00);
        chk("first_step_dir", dir, 3);

        // Reverse key dropped, up accepted
        key(K_LEFT);
        #1;
        chk("rev_drop_next_x", next_x, 11);
        key(K_UP);
        #1;
        chk("up_next_y", next_y, 9);
        ticks(5);
        do_tick(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 8'h00);
        chk("up_dir", dir, 0);

        // Arrow coinciding with the evaluating tick applies to the next move
        ticks(5);
        do_tick(1'b1, 1'b0, 2'd0, 1'b0, 1'b1, K_LEFT);
        #1;
        chk("coincide_dir", dir, 0);
        chk("coincide_next_x", next_x, 9);

        // Pause mid-count holds the counter
        ticks(3);
        key(K_SPACE);
        chk("pause_screen", screen_pause, 1);
        ticks(10);
        key(K_SPACE);
        chk("resume_screen", screen_pause, 0);
        ticks(2);
        do_tick(1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 8'h00);
        chk("resume_dir", dir, 2);

        // Score saturation
        food(10);
        chk("score_10", score, 10);
        food(290);
        chk("score_sat", score, 255);

        // Self collision
        ticks(5);
        do_tick(1'b1, 1'b1, 2'd2, 1'b1, 1'b0, 8'h00);
        chk("dead_pause", screen_pause, 1);
        chk("dead_dir", dir, 2);
        key(K_SPACE);
        chk("dead_idle_init", init_snake, 1);
        chk("dead_idle_dir", dir, 3);
        chk("dead_idle_pause", screen_pause, 0);

        // Right wall
        key(K_SPACE);
        chk("rerun_score_clr", score, 0);
        head_x = 7'd63;
        #1;
`ifdef SNAKE_WRAP_EN
        chk("wall_next_x", next_x, 0);
        ticks(5);
        do_tick(1'b1, 1'b0, 2'd3, 1'b0, 1'b0, 8'h00);
        chk("wall_pause", screen_pause, 0);
`else
        chk("wall_next_x", next_x, 64);
        ticks(5);
        do_tick(1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 8'h00);
        chk("wall_pause", screen_pause, 1);
`endif

        // Reset during RUN aborts the pending step
        key(K_ESC);
        key(K_SPACE);
        head_x = 7'd10;
        head_y = 6'd10;
        food(3);
        chk("pre_rst_score", score, 3);
        key(K_UP);
        ticks(5);
        @(negedge clk);
        frame_tick = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        chk_reset_vals("midrst");
        chk("midrst_next_x", next_x, 11);
        chk("midrst_next_y", next_y, 10);
        rst = 1'b0;

        key(K_SPACE);
        ticks(5);
        do_tick(1'b1, 1'b0, 2'd3, 1'b0, 1'b0, 8'h00);

        repeat (4) @(negedge clk);
        chk("events_outstanding", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
